// File: rtl/cpu_hazard_ctl.sv
// Hazard and forwarding controller for the MCS8 pipeline.
// It resolves the two D-stage operands from the M/W bypass network and
// detects load-use hazards against E and M. A memory-wait FSM freezes the
// pipe while data memory is slow, and raises a sticky fault on timeout.
// A saturating counter records every cycle in which F/D is held.
module cpu_hazard_ctl #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          CLK_I,
  input  logic          RSTN_I,
  input  logic [DW-1:0] REG_A_I,
  input  logic [DW-1:0] REG_B_I,
  input  logic [AW-1:0] SRC_A_I,
  input  logic [AW-1:0] SRC_B_I,
  input  logic          USE_A_I,
  input  logic          USE_B_I,
  input  logic [AW-1:0] E_DST_I,
  input  logic          E_VALID_I,
  input  logic          E_WR_I,
  input  logic          E_LOAD_I,
  input  logic [AW-1:0] M_DST_I,
  input  logic          M_VALID_I,
  input  logic          M_WR_I,
  input  logic          M_LOAD_I,
  input  logic          M_MEM_I,
  input  logic [DW-1:0] M_VAL_I,
  input  logic          MEM_RDY_I,
  input  logic [AW-1:0] W_DST_I,
  input  logic          W_VALID_I,
  input  logic          W_WR_I,
  input  logic [DW-1:0] W_VAL_I,
  input  logic          CNT_CLR_I,
  output logic [DW-1:0] OPA_O,
  output logic [DW-1:0] OPB_O,
  output logic          STALL_FD_O,
  output logic          BUBBLE_E_O,
  output logic          FREEZE_O,
  output logic          FAULT_O,
  output logic [CW-1:0] STALL_CNT_O,
  output logic [1:0]    STATE_O
);

  // Encoding is visible on STATE_O: 0 = RUN, 1 = MEMWAIT, 2 = FAULT.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FAULT   = 2'd2
  } state_t;

  // The wait counter never needs to hold more than TIMEOUT.
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt, wait_inc;
  logic           m_a, m_b, w_a, w_b, e_a, e_b;
  logic           lu, memreq, freeze, stall;
  logic           fault_q;
  logic [CW-1:0]  stall_cnt;

  // Bypass matching, operand mux (M > W > bank) and load-use detection.
  // A load in M matches but cannot forward yet; the stall covers it.
  always_comb begin
    m_a   = M_VALID_I & M_WR_I & (M_DST_I == SRC_A_I);
    m_b   = M_VALID_I & M_WR_I & (M_DST_I == SRC_B_I);
    w_a   = W_VALID_I & W_WR_I & (W_DST_I == SRC_A_I);
    w_b   = W_VALID_I & W_WR_I & (W_DST_I == SRC_B_I);
    e_a   = E_VALID_I & E_WR_I & E_LOAD_I & (E_DST_I == SRC_A_I);
    e_b   = E_VALID_I & E_WR_I & E_LOAD_I & (E_DST_I == SRC_B_I);
    OPA_O = REG_A_I;
    OPB_O = REG_B_I;
    if (m_a && !M_LOAD_I)  OPA_O = M_VAL_I;
    else if (!m_a && w_a)  OPA_O = W_VAL_I;
    if (m_b && !M_LOAD_I)  OPB_O = M_VAL_I;
    else if (!m_b && w_b)  OPB_O = W_VAL_I;
    lu = (USE_A_I & (e_a | (m_a & M_LOAD_I))) |
         (USE_B_I & (e_b | (m_b & M_LOAD_I)));
  end

  // Memory-wait next state, wait counting and the freeze request.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    wait_inc  = wait_cnt + 1'b1;
    freeze    = 1'b0;
    memreq    = M_VALID_I & M_MEM_I & ~MEM_RDY_I;
    case (state)
      RUN: begin
        if (memreq) begin
          freeze = 1'b1;
          if (TIMEOUT == 1) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = MEMWAIT;
            wait_nxt  = WCW'(1);
          end
        end
      end
      MEMWAIT: begin
        if (MEM_RDY_I) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          freeze = 1'b1;
          if (wait_inc == WCW'(TIMEOUT)) state_nxt = FAULT;
          else                           wait_nxt  = wait_inc;
        end
      end
      FAULT:   freeze = 1'b1;
      default: state_nxt = RUN;
    endcase
    stall = lu | freeze;
  end

  // State, wait counter and the registered fault flag.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state    <= RUN;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      fault_q  <= (state_nxt == FAULT);
    end
  end

  // Saturating stall-cycle counter; clear wins over a same-cycle increment.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I)                       stall_cnt <= '0;
    else if (CNT_CLR_I)                stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

  assign FREEZE_O    = freeze;
  assign STALL_FD_O  = stall;
  assign BUBBLE_E_O  = lu & ~freeze;
  assign FAULT_O     = fault_q;
  assign STALL_CNT_O = stall_cnt;
  assign STATE_O     = state;

endmodule

// File: tb/tb_cpu_hazard_ctl.sv
// Bench for cpu_hazard_ctl (TIMEOUT=4, CW=4). The driver applies one directed
// vector per cycle just after the rising edge and pushes the hand-computed
// response; a monitor pops it on the falling edge and compares every output.
module tb_cpu_hazard_ctl;

  localparam int EW = 26;  // {opa, opb, stall, bubble, freeze, fault, cnt, state}
  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_FAULT = 2'd2;

  logic       clk, rst_n;
  logic [7:0] reg_a, reg_b, m_val, w_val;
  logic [2:0] src_a, src_b, e_dst, m_dst, w_dst;
  logic       use_a, use_b, e_valid, e_wr, e_load;
  logic       m_valid, m_wr, m_load, m_mem, mem_rdy;
  logic       w_valid, w_wr, cnt_clr;
  logic [7:0] opa, opb;
  logic       stall_fd, bubble_e, freeze, fault;
  logic [3:0] stall_cnt;
  logic [1:0] state;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  cpu_hazard_ctl #(.DW(8), .AW(3), .TIMEOUT(4), .CW(4)) dut (
    .CLK_I(clk), .RSTN_I(rst_n),
    .REG_A_I(reg_a), .REG_B_I(reg_b),
    .SRC_A_I(src_a), .SRC_B_I(src_b),
    .USE_A_I(use_a), .USE_B_I(use_b),
    .E_DST_I(e_dst), .E_VALID_I(e_valid), .E_WR_I(e_wr), .E_LOAD_I(e_load),
    .M_DST_I(m_dst), .M_VALID_I(m_valid), .M_WR_I(m_wr), .M_LOAD_I(m_load),
    .M_MEM_I(m_mem), .M_VAL_I(m_val), .MEM_RDY_I(mem_rdy),
    .W_DST_I(w_dst), .W_VALID_I(w_valid), .W_WR_I(w_wr), .W_VAL_I(w_val),
    .CNT_CLR_I(cnt_clr),
    .OPA_O(opa), .OPB_O(opb), .STALL_FD_O(stall_fd), .BUBBLE_E_O(bubble_e),
    .FREEZE_O(freeze), .FAULT_O(fault), .STALL_CNT_O(stall_cnt), .STATE_O(state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected response per cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("opa",       opa,               e[25:18]);
      check("opb",       opb,               e[17:10]);
      check("stall_fd",  {7'd0, stall_fd},  {7'd0, e[9]});
      check("bubble_e",  {7'd0, bubble_e},  {7'd0, e[8]});
      check("freeze",    {7'd0, freeze},    {7'd0, e[7]});
      check("fault",     {7'd0, fault},     {7'd0, e[6]});
      check("stall_cnt", {4'd0, stall_cnt}, {4'd0, e[5:2]});
      check("state",     {6'd0, state},     {6'd0, e[1:0]});
    end
  end

  // Driver: push the response expected for the inputs now applied, then
  // advance to just after the next rising edge.
  task automatic step(input logic [7:0] e_opa, input logic [7:0] e_opb,
                      input logic e_st, input logic e_bu, input logic e_fr,
                      input logic e_fa, input logic [3:0] e_cnt, input logic [1:0] e_s);
    exp_q.push_back({e_opa, e_opb, e_st, e_bu, e_fr, e_fa, e_cnt, e_s});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_a = 8'hA0; reg_b = 8'hB0; m_val = 8'h00; w_val = 8'h00;
    src_a = 3'd0; src_b = 3'd0; use_a = 1'b0; use_b = 1'b0;
    e_dst = 3'd0; e_valid = 1'b0; e_wr = 1'b0; e_load = 1'b0;
    m_dst = 3'd0; m_valid = 1'b0; m_wr = 1'b0; m_load = 1'b0; m_mem = 1'b0;
    mem_rdy = 1'b1;
    w_dst = 3'd0; w_valid = 1'b0; w_wr = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic m_load_pending();
    m_valid = 1'b1; m_wr = 1'b1; m_load = 1'b1; m_mem = 1'b1; m_dst = 3'd7;
    mem_rdy = 1'b0;
  endtask

  task automatic e_load_hazard_b();
    e_valid = 1'b1; e_wr = 1'b1; e_load = 1'b1; e_dst = 3'd2;
    src_b = 3'd2; use_b = 1'b1;
  endtask

  // Directed stimulus with hand-computed responses.
  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd0, S_RUN);        // in reset
    rst_n = 1'b1;
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd0, S_RUN);

    // Forwarding priority M > W > bank.
    reg_a = 8'h00; src_a = 3'd3;
    m_valid = 1; m_wr = 1; m_dst = 3'd3; m_val = 8'h5A;
    w_valid = 1; w_wr = 1; w_dst = 3'd3; w_val = 8'h11;
    step(8'h5A, 8'hB0, 0, 0, 0, 0, 4'd0, S_RUN);
    m_valid = 0;
    step(8'h11, 8'hB0, 0, 0, 0, 0, 4'd0, S_RUN);
    w_valid = 0;
    step(8'h00, 8'hB0, 0, 0, 0, 0, 4'd0, S_RUN);
    m_valid = 1; w_valid = 1; w_dst = 3'd5; src_a = 3'd5; src_b = 3'd3;
    step(8'h11, 8'h5A, 0, 0, 0, 0, 4'd0, S_RUN);          // A from W, B from M
    m_load = 1; m_mem = 1; w_dst = 3'd3; src_a = 3'd3;    // load in M: bank value
    step(8'h00, 8'hB0, 0, 0, 0, 0, 4'd0, S_RUN);
    use_a = 1;                                            // load-use on M
    step(8'h00, 8'hB0, 1, 1, 0, 0, 4'd0, S_RUN);

    // Load-use against E.
    idle();
    e_load_hazard_b();
    step(8'hA0, 8'hB0, 1, 1, 0, 0, 4'd1, S_RUN);
    use_b = 0;
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd2, S_RUN);
    use_b = 1; e_load = 0;                                // non-load in E: no hazard
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd2, S_RUN);

    // Memory wait: three not-ready cycles, then ready.
    idle();
    m_load_pending();
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd2, S_RUN);
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd3, S_WAIT);
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd4, S_WAIT);
    mem_rdy = 1;
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd5, S_WAIT);
    idle();
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd5, S_RUN);

    // Freeze overrides bubble; hazard re-evaluated after release.
    m_load_pending();
    e_load_hazard_b();
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd5, S_RUN);
    mem_rdy = 1;
    step(8'hA0, 8'hB0, 1, 1, 0, 0, 4'd6, S_WAIT);
    idle();
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd7, S_RUN);

    // Timeout: fault at the edge ending the 4th not-ready cycle.
    m_load_pending();
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd7,  S_RUN);
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd8,  S_WAIT);
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd9,  S_WAIT);
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd10, S_WAIT);
    mem_rdy = 1;
    step(8'hA0, 8'hB0, 1, 0, 1, 1, 4'd11, S_FAULT);
    idle();
    cnt_clr = 1;                                          // clear does not leave FAULT
    step(8'hA0, 8'hB0, 1, 0, 1, 1, 4'd12, S_FAULT);
    cnt_clr = 0;
    step(8'hA0, 8'hB0, 1, 0, 1, 1, 4'd0,  S_FAULT);
    rst_n = 1'b0;                                         // asynchronous reset
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd0, S_RUN);
    rst_n = 1'b1;
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd0, S_RUN);

    // Saturation at 15, then clear with the hazard still present.
    e_load_hazard_b();
    for (int k = 0; k < 20; k++)
      step(8'hA0, 8'hB0, 1, 1, 0, 0, (k > 15) ? 4'd15 : 4'(k), S_RUN);
    cnt_clr = 1;
    step(8'hA0, 8'hB0, 1, 1, 0, 0, 4'd15, S_RUN);
    cnt_clr = 0;
    step(8'hA0, 8'hB0, 1, 1, 0, 0, 4'd0, S_RUN);
    idle();
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd1, S_RUN);

    // Reset in the middle of a wait: state clears, freeze follows inputs.
    m_load_pending();
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd1, S_RUN);
    rst_n = 1'b0;
    step(8'hA0, 8'hB0, 1, 0, 1, 0, 4'd0, S_RUN);
    idle();
    rst_n = 1'b1;
    step(8'hA0, 8'hB0, 0, 0, 0, 0, 4'd0, S_RUN);

    // Report.
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
